// File: rtl/systolic_skew_feeder.sv
// Diagonal-wavefront operand feeder between the 4x4 operand memory and the PE array.
// Optional zero-fill drain phase enabled by defining FEEDER_DRAIN_EN.
module systolic_skew_feeder #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stall,
   output logic [3:0]              mem_read_enable,
   output logic [7:0]              mem_read_elem,
   input  logic [4*DATA_WIDTH-1:0] mem_data,
   output logic [4*DATA_WIDTH-1:0] a_out,
   output logic                    a_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned LANES     = 4;
   localparam int unsigned WORD_W    = LANES * DATA_WIDTH;
   localparam logic [2:0]  LAST_STEP = 3'd6;

`ifdef FEEDER_DRAIN_EN
   localparam int unsigned          DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;
`else
   typedef enum logic [1:0] {IDLE, FEED} state_e;
`endif

   state_e              state_q, state_d;
   logic [2:0]          step_q, step_d;
   logic [WORD_W-1:0]   a_out_q, a_out_d;
   logic                a_valid_q, a_valid_d;
   logic                done_q, done_d;
`ifdef FEEDER_DRAIN_EN
   logic [DRAIN_W-1:0]  drain_q, drain_d;
`endif

   // Column c reads row (step - c) while that difference lies in 0..3.
   always_comb begin : addr_gen
      logic [2:0] rel;
      mem_read_enable = '0;
      mem_read_elem   = '0;
      rel             = '0;
      if (state_q == FEED) begin
         for (int unsigned c = 0; c < LANES; c++) begin
            rel = step_q - 3'(c);
            if ((step_q >= 3'(c)) && (rel <= 3'd3)) begin
               mem_read_enable[c]      = 1'b1;
               mem_read_elem[2*c +: 2] = rel[1:0];
            end
         end
      end
   end

   assign busy    = (state_q != IDLE);
   assign a_out   = a_out_q;
   assign a_valid = a_valid_q;
   assign done    = done_q;

   // Next-state and capture logic.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      a_out_d   = a_out_q;
      a_valid_d = 1'b0;
      done_d    = 1'b0;
`ifdef FEEDER_DRAIN_EN
      drain_d   = drain_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FEED;
               step_d  = '0;
            end
         end
         FEED: begin
            if (!stall) begin
               a_out_d   = mem_data;
               a_valid_d = 1'b1;
               if (step_q == LAST_STEP) begin
                  step_d = '0;
`ifdef FEEDER_DRAIN_EN
                  state_d = DRAIN;
                  drain_d = '0;
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
`ifdef FEEDER_DRAIN_EN
         DRAIN: begin
            if (!stall) begin
               a_out_d   = '0;
               a_valid_d = 1'b1;
               if (drain_q == DRAIN_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  drain_d = drain_q + DRAIN_W'(1);
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         a_out_q   <= '0;
         a_valid_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef FEEDER_DRAIN_EN
         drain_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         a_out_q   <= a_out_d;
         a_valid_q <= a_valid_d;
         done_q    <= done_d;
`ifdef FEEDER_DRAIN_EN
         drain_q   <= drain_d;
`endif
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: memory model, stimulus process and output monitor.
module tb_systolic_skew_feeder;

   localparam int unsigned DW      = 8;
   localparam int unsigned DRAIN_N = 4;
`ifdef FEEDER_DRAIN_EN
   localparam int NOMINAL = 8 + DRAIN_N;
`else
   localparam int NOMINAL = 8;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          stall;
   logic [3:0]    mem_read_enable;
   logic [7:0]    mem_read_elem;
   logic [4*DW-1:0] mem_data;
   logic [4*DW-1:0] a_out;
   logic          a_valid;
   logic          busy;
   logic          done;

   systolic_skew_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN_N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .stall           (stall),
      .mem_read_enable (mem_read_enable),
      .mem_read_elem   (mem_read_elem),
      .mem_data        (mem_data),
      .a_out           (a_out),
      .a_valid         (a_valid),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous-read operand memory: mem[column][row]; disabled lanes read 0.
   logic [7:0] mem [4][4];
   always_comb begin
      mem_data = '0;
      for (int c = 0; c < 4; c++)
         if (mem_read_enable[c])
            mem_data[8*c +: 8] = mem[c][mem_read_elem[2*c +: 2]];
   end

   typedef struct {
      logic [31:0] data;
      logic        done;
      int          step;
   } beat_t;

   beat_t       sb[$];
   logic [31:0] last_a;
   int          errors;
   int          checks;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected {row selects, enables} while presenting wavefront step s (zero in drain).
   function automatic logic [11:0] exp_addr(input int s);
      logic [3:0] en;
      logic [7:0] el;
      en = '0;
      el = '0;
      for (int c = 0; c < 4; c++)
         if (s <= 6 && s >= c && s - c <= 3) begin
            en[c]        = 1'b1;
            el[2*c +: 2] = 2'(s - c);
         end
      return {el, en};
   endfunction

   // Tile as the array should see it: beat k carries column c's row (k - c), else 0.
   task automatic push_tile();
      beat_t b;
      for (int k = 0; k < 7; k++) begin
         b.data = '0;
         for (int c = 0; c < 4; c++)
            if (k >= c && k - c <= 3)
               b.data[8*c +: 8] = mem[c][k - c];
`ifdef FEEDER_DRAIN_EN
         b.done = 1'b0;
`else
         b.done = (k == 6);
`endif
         b.step = k;
         sb.push_back(b);
      end
`ifdef FEEDER_DRAIN_EN
      for (int k = 0; k < DRAIN_N; k++) begin
         b.data = '0;
         b.done = (k == DRAIN_N - 1);
         b.step = 7 + k;
         sb.push_back(b);
      end
`endif
   endtask

   // Monitor: pops on every valid beat, checks hold/idle behaviour otherwise.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (a_valid) begin
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_beat: actual a_out=%h required no beat", a_out);
            end else begin
               e = sb.pop_front();
               check("beat_data", a_out, e.data);
               check("beat_done", 32'(done), 32'(e.done));
               last_a = e.data;
            end
         end else begin
            check("a_out_hold", a_out, last_a);
            check("done_without_valid", 32'(done), 32'd0);
         end
         if (busy) begin
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL busy_without_tile: actual busy=1 required busy=0");
            end else begin
               check("addr", 32'({mem_read_elem, mem_read_enable}), 32'(exp_addr(sb[0].step)));
            end
         end else begin
            check("idle_addr", 32'({mem_read_elem, mem_read_enable}), 32'd0);
         end
      end
   end

   // mode 0: clean; 1: 3-cycle stall at step 2; 2: random stall/start; 3: start at steps 3 and 6; 4: reset at step 4
   task automatic run_tile(input int mode, output int cycles, output bit aborted);
      bit got_done;
      int stall_left;
      bit stall_used;
      got_done   = 0;
      aborted    = 0;
      stall_left = 0;
      stall_used = 0;
      cycles     = 0;
      push_tile();
      start = 1'b1;
      while (!got_done && !aborted && cycles < 300) begin
         @(posedge clk);
         #2;
         cycles++;
         start = 1'b0;
         if (done) got_done = 1;
         case (mode)
            0: begin
               if (cycles == 1) check("latency_edge1", 32'({a_valid, busy}), 32'b01);
               if (cycles == 2) check("latency_edge2", 32'(a_valid), 32'd1);
            end
            1: begin
               if (stall_left > 0) begin
                  stall_left--;
               end else begin
                  stall = 1'b0;
                  if (!stall_used && busy && mem_read_enable == 4'h7) begin
                     stall      = 1'b1;
                     stall_left = 2;
                     stall_used = 1;
                  end
               end
            end
            2: begin
               stall = ($urandom_range(0, 3) == 0);
               if (sb.size() >= 3 && $urandom_range(0, 5) == 0) start = 1'b1;
            end
            3: begin
               if (busy && (mem_read_enable == 4'hF || mem_read_enable == 4'h8)) start = 1'b1;
            end
            4: begin
               if (busy && mem_read_enable == 4'hE) begin
                  sb.delete();
                  last_a = '0;
                  rst_n  = 1'b0;
                  #1;
                  check("rst_a_out", a_out, 32'd0);
                  check("rst_flags", 32'({a_valid, done, busy}), 32'd0);
                  check("rst_addr", 32'({mem_read_elem, mem_read_enable}), 32'd0);
                  @(posedge clk);
                  @(posedge clk);
                  #2;
                  rst_n = 1'b1;
                  for (int i = 0; i < 3; i++) begin
                     @(posedge clk);
                     #2;
                     check("post_rst_idle", 32'({busy, a_valid, done}), 32'd0);
                  end
                  aborted = 1;
               end
            end
            default: ;
         endcase
      end
      stall = 1'b0;
      start = 1'b0;
      if (!aborted) begin
         check("tile_done_seen", 32'(got_done), 32'd1);
         @(negedge clk);
         #1;
         check("tile_drained", 32'(sb.size()), 32'd0);
      end
   endtask

   initial begin
      int  cyc;
      bit  ab;
      errors = 0;
      checks = 0;
      last_a = '0;
      rst_n  = 1'b0;
      start  = 1'b0;
      stall  = 1'b0;
      for (int c = 0; c < 4; c++)
         for (int e = 0; e < 4; e++)
            mem[c][e] = 8'(16 * c + e);
      repeat (2) @(posedge clk);
      #2;
      check("reset_a_out", a_out, 32'd0);
      check("reset_flags", 32'({a_valid, done, busy}), 32'd0);
      check("reset_addr", 32'({mem_read_elem, mem_read_enable}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      run_tile(0, cyc, ab);
      check("clean_done_cycle", 32'(cyc), 32'(NOMINAL));
      repeat (2) @(posedge clk);
      #2;
      run_tile(1, cyc, ab);
      check("stall_done_cycle", 32'(cyc), 32'(NOMINAL + 3));
      repeat (2) @(posedge clk);
      #2;
      run_tile(3, cyc, ab);
      repeat (3) @(posedge clk);
      #2;
      check("start_while_busy_ignored", 32'(busy), 32'd0);
      run_tile(4, cyc, ab);
      check("reset_abort_taken", 32'(ab), 32'd1);
      run_tile(0, cyc, ab);
      check("after_reset_done_cycle", 32'(cyc), 32'(NOMINAL));

      for (int t = 0; t < 20; t++) begin
         for (int c = 0; c < 4; c++)
            for (int e = 0; e < 4; e++)
               mem[c][e] = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
         run_tile(2, cyc, ab);
      end

      repeat (4) @(posedge clk);
      #2;
      check("final_idle", 32'({busy, a_valid}), 32'd0);
      check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
